// File: rtl/e203_exu_bjp_pipe.sv
// Branch/jump resolution stage with its own comparator, target and link adders.
// Optional statistics counters are enabled by defining E203_BJP_PERF_CNT_EN.
module e203_exu_bjp_pipe #(
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32,
    parameter int HAS_RVC = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bjp_i_valid,
    output logic               bjp_i_ready,
    input  logic [XLEN-1:0]    bjp_i_rs1,
    input  logic [XLEN-1:0]    bjp_i_rs2,
    input  logic [XLEN-1:0]    bjp_i_imm,
    input  logic [PC_SIZE-1:0] bjp_i_pc,
    input  logic               bjp_i_bxx,
    input  logic               bjp_i_jal,
    input  logic               bjp_i_jalr,
    input  logic [2:0]         bjp_i_func,
    input  logic               bjp_i_rv32,
    input  logic               bjp_i_bprdt,
    input  logic               bjp_i_flush,
    output logic               bjp_o_valid,
    input  logic               bjp_o_ready,
    output logic [XLEN-1:0]    bjp_o_wbck_wdat,
    output logic               bjp_o_wbck_en,
    output logic               bjp_o_rslv,
    output logic               bjp_o_prdt,
    output logic               bjp_o_flush_req,
    output logic [PC_SIZE-1:0] bjp_o_flush_pc,
`ifdef E203_BJP_PERF_CNT_EN
    output logic [CNT_W-1:0]   bjp_o_br_cnt,
    output logic [CNT_W-1:0]   bjp_o_mis_cnt,
`endif
    output logic               bjp_o_misalgn
);

    logic               sel_jalr, sel_jal, sel_bxx;
    logic               cmp, accept;
    logic [XLEN-1:0]    jalr_sum;
    logic [PC_SIZE-1:0] tgt_raw;
    logic [PC_SIZE-1:0] tgt_d, lnk_d, fpc_d;
    logic [XLEN-1:0]    wdat_d;
    logic               rslv_d, misalgn_d, flush_req_d, wbck_en_d;

    logic               valid_q, wbck_en_q, rslv_q, prdt_q, flush_req_q, misalgn_q;
    logic [XLEN-1:0]    wdat_q;
    logic [PC_SIZE-1:0] fpc_q;

    // jalr > jal > bxx when more than one kind is flagged
    assign sel_jalr = bjp_i_jalr;
    assign sel_jal  = ~bjp_i_jalr & bjp_i_jal;
    assign sel_bxx  = ~bjp_i_jalr & ~bjp_i_jal & bjp_i_bxx;

    always_comb begin
        cmp = 1'b0;
        unique case (bjp_i_func)
            3'b000:  cmp = (bjp_i_rs1 == bjp_i_rs2);
            3'b001:  cmp = (bjp_i_rs1 != bjp_i_rs2);
            3'b100:  cmp = ($signed(bjp_i_rs1) <  $signed(bjp_i_rs2));
            3'b101:  cmp = ($signed(bjp_i_rs1) >= $signed(bjp_i_rs2));
            3'b110:  cmp = (bjp_i_rs1 <  bjp_i_rs2);
            3'b111:  cmp = (bjp_i_rs1 >= bjp_i_rs2);
            default: cmp = 1'b0;
        endcase
    end

    assign jalr_sum = bjp_i_rs1 + bjp_i_imm;
    assign tgt_raw  = sel_jalr ? jalr_sum[PC_SIZE-1:0]
                               : bjp_i_pc + bjp_i_imm[PC_SIZE-1:0];
    assign tgt_d    = sel_jalr ? {tgt_raw[PC_SIZE-1:1], 1'b0} : tgt_raw;
    assign lnk_d    = bjp_i_pc + (bjp_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
    assign wdat_d   = XLEN'(lnk_d);

    assign rslv_d    = sel_jalr | sel_jal | (sel_bxx & cmp);
    assign misalgn_d = rslv_d & ((HAS_RVC != 0) ? 1'b0 : tgt_d[1]);
    assign fpc_d     = rslv_d ? tgt_d : lnk_d;

    always_comb begin
        flush_req_d = 1'b0;
        if (sel_jalr)     flush_req_d = 1'b1;
        else if (sel_bxx) flush_req_d = rslv_d ^ bjp_i_bprdt;
        if (misalgn_d)    flush_req_d = 1'b0;
    end

    assign wbck_en_d = (sel_jalr | sel_jal) & ~misalgn_d;

    assign bjp_i_ready = ~valid_q | bjp_o_ready;
    assign accept      = bjp_i_valid & bjp_i_ready & ~bjp_i_flush;

    always_ff @(posedge clk) begin
        if (rst)              valid_q <= 1'b0;
        else if (bjp_i_flush) valid_q <= 1'b0;
        else if (accept)      valid_q <= 1'b1;
        else if (bjp_o_ready) valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbck_en_q   <= 1'b0;
            rslv_q      <= 1'b0;
            prdt_q      <= 1'b0;
            flush_req_q <= 1'b0;
            misalgn_q   <= 1'b0;
            wdat_q      <= '0;
            fpc_q       <= '0;
        end else if (accept) begin
            wbck_en_q   <= wbck_en_d;
            rslv_q      <= rslv_d;
            prdt_q      <= bjp_i_bprdt;
            flush_req_q <= flush_req_d;
            misalgn_q   <= misalgn_d;
            wdat_q      <= wdat_d;
            fpc_q       <= fpc_d;
        end
    end

`ifdef E203_BJP_PERF_CNT_EN
    logic             isbr_q, fire;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    // a result dropped by flush in the same cycle is not counted
    assign fire = valid_q & bjp_o_ready & ~bjp_i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            isbr_q    <= 1'b0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (accept) isbr_q <= sel_bxx;
            if (fire & isbr_q & ~&br_cnt_q)       br_cnt_q  <= br_cnt_q + 1'b1;
            if (fire & flush_req_q & ~&mis_cnt_q) mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign bjp_o_br_cnt  = br_cnt_q;
    assign bjp_o_mis_cnt = mis_cnt_q;
`endif

    assign bjp_o_valid     = valid_q;
    assign bjp_o_wbck_wdat = wdat_q;
    assign bjp_o_wbck_en   = wbck_en_q;
    assign bjp_o_rslv      = rslv_q;
    assign bjp_o_prdt      = prdt_q;
    assign bjp_o_flush_req = flush_req_q;
    assign bjp_o_flush_pc  = fpc_q;
    assign bjp_o_misalgn   = misalgn_q;

endmodule

// File: doc/e203_exu_bjp_pipe.md
Name: e203_exu_bjp_pipe

Overview:
- Parametrised, self-contained branch/jump resolution unit for the EXU; successor to the ALU-shared BJP path.
- Owns its comparator and two adders (target and link), so no ALU borrowing.
- Registers results in one pipeline stage with valid/ready backpressure.
- Produces link writeback, resolved direction, redirect target, mispredict flush request and misalignment error toward commit.

Parameters:
XLEN, 32, operand/writeback width
PC_SIZE, 32, PC/target width (PC_SIZE <= XLEN)
HAS_RVC, 1, 1: 2-byte instruction alignment legal; 0: 4-byte alignment required
CNT_W, 16, width of optional statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
bjp_i_valid  in  1  request valid
bjp_i_ready  out  1  request accepted when valid&ready
bjp_i_rs1  in  XLEN  operand 1
bjp_i_rs2  in  XLEN  operand 2
bjp_i_imm  in  XLEN  sign-extended offset
bjp_i_pc  in  PC_SIZE  instruction PC
bjp_i_bxx  in  1  conditional branch
bjp_i_jal  in  1  JAL
bjp_i_jalr  in  1  JALR
bjp_i_func  in  3  compare code: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu
bjp_i_rv32  in  1  1: 4-byte instruction, 0: 2-byte
bjp_i_bprdt  in  1  predicted taken
bjp_i_flush  in  1  kill stage register and any same-cycle accept
bjp_o_valid  out  1  result valid
bjp_o_ready  in  1  result consumed when valid&ready
bjp_o_wbck_wdat  out  XLEN  link value (pc + 4 or 2), zero-extended
bjp_o_wbck_en  out  1  link writeback required (jal|jalr)
bjp_o_rslv  out  1  resolved taken
bjp_o_prdt  out  1  registered prediction
bjp_o_flush_req  out  1  redirect needed
bjp_o_flush_pc  out  PC_SIZE  redirect address
bjp_o_misalgn  out  1  taken target misaligned

Behaviour:
- Latency: 1 cycle from accept to bjp_o_valid. Throughput: 1 per cycle.
- bjp_i_ready = ~bjp_o_valid | bjp_o_ready; combinational, no dependency on bjp_i_valid.
- Accept: valid&ready&~flush loads the stage; o_valid<=1. If o_valid&o_ready and no accept: o_valid<=0. Registered outputs hold stable while o_valid&~o_ready.
- bjp_i_flush: o_valid<=0 next cycle regardless of handshakes; flush beats simultaneous accept.
- rst: all outputs 0 next edge (o_valid, wbck_en, rslv, prdt, flush_req, misalgn, wdat, flush_pc); mid-operation pending result is discarded.
- Compare: eq/ne on full XLEN; lt/ge signed; ltu/geu unsigned. Any other func code with bxx: rslv=0.
- rslv = jal|jalr ? 1 : (bxx ? cmp : 0).
- Target: jalr: (rs1+imm) with bit0 cleared; else pc+imm; truncated to PC_SIZE, wraps modulo 2^PC_SIZE.
- Link/fall-through: pc + (rv32 ? 4 : 2), wraps modulo 2^PC_SIZE.
- flush_req: bxx: rslv^prdt; jalr: 1; jal: 0.
- flush_pc = rslv ? target : fall-through.
- misalgn = rslv & (HAS_RVC ? 0 : target[1]). When misalgn=1, flush_req forced 0; wbck_en forced 0.
- More than one of bxx/jal/jalr set: priority jalr > jal > bxx. None set: pass-through, rslv=0, flush_req=0, wbck_en=0.

Optional Feature:
E203_BJP_PERF_CNT_EN
- Defined: adds outputs bjp_o_br_cnt[CNT_W] and bjp_o_mis_cnt[CNT_W].
  - br_cnt increments on each o_valid&o_ready with bxx.
  - mis_cnt increments on each o_valid&o_ready with flush_req.
  - Both saturate at all-ones and clear on rst.
  - Results killed by bjp_i_flush are not counted.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, bprdt=0, o_ready=1 -> next cycle o_valid=1, rslv=1, flush_req=1, flush_pc=0x120.
- BLT rs1=0xFFFFFFFF, rs2=1 -> rslv=1. BLTU with the same operands -> rslv=0.
- JALR rs1=0x203, imm=0, rv32=1, pc=0x80 -> flush_pc=0x202, wbck_en=1, wdat=0x84, flush_req=1.
- HAS_RVC=0, JAL pc=0x100, imm=0x6 -> misalgn=1, flush_req=0, wbck_en=0. HAS_RVC=1 -> misalgn=0.
- o_ready=0 for 3 cycles with a valid result -> i_ready=0, outputs stable. Then o_ready=1 with a new input -> back-to-back transfer, no bubble.
- Flush asserted with a result held and a new valid input -> o_valid=0 next cycle. With PERF enabled, counters unchanged. Pulse rst mid-stall -> all outputs 0.
